ws2812_frame_sequencer: RTL and testbench

- Sequences one complete WS2812 strip refresh, called a frame, through the single-pixel ws2812 driver.
- Per frame: NUM_LEDS pixel loads, then one latch (ws_reset) pulse.
- Frames are requested by edges on the flash-rate level from the clock divider, or by an explicit refresh strobe.
- Sits between clock_divider and ws2812 in the top level and replaces the ad-hoc main loop.

---
 rtl/ws2812_frame_sequencer.sv | 115 +++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer for a WS2812 strip: one frame is NUM_LEDS pixel loads followed by one latch.
// Frames are requested by a flash-level edge or a refresh strobe and are paced by the driver's ready.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS = 10,
  parameter int IDX_W = 8,
  parameter logic [7:0] ON_R = 8'h3F,
  parameter logic [7:0] ON_G = 8'h3F,
  parameter logic [7:0] ON_B = 8'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flash_level,
  input  logic             refresh,
  input  logic             drv_ready,
  output logic             drv_load,
  output logic             drv_ws_reset,
  output logic [7:0]       drv_r,
  output logic [7:0]       drv_g,
  output logic [7:0]       drv_b,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] led_index
);

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_WAIT, LATCH, LATCH_WAIT, DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  state_t state;
  logic   level_q;
  logic   pending;
  logic   guard;
  logic   request;

  assign request = (flash_level != level_q) || refresh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      level_q      <= 1'b0;
      pending      <= 1'b0;
      guard        <= 1'b0;
      drv_load     <= 1'b0;
      drv_ws_reset <= 1'b0;
      drv_r        <= 8'h00;
      drv_g        <= 8'h00;
      drv_b        <= 8'h00;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      led_index    <= '0;
    end else begin
      level_q      <= flash_level;
      drv_load     <= 1'b0;
      drv_ws_reset <= 1'b0;
      frame_done   <= 1'b0;
      if (request) pending <= 1'b1;

      case (state)
        IDLE: begin
          // The frame start samples the level, so a request in this same cycle is already served.
          if (pending && enable && drv_ready) begin
            state     <= LOAD;
            pending   <= 1'b0;
            led_index <= '0;
            busy      <= 1'b1;
            drv_load  <= 1'b1;
            drv_r     <= flash_level ? ON_R : 8'h00;
            drv_g     <= flash_level ? ON_G : 8'h00;
            drv_b     <= flash_level ? ON_B : 8'h00;
          end
        end
        LOAD: begin
          state <= LOAD_WAIT;
          guard <= 1'b1;
        end
        LOAD_WAIT: begin
          // The driver drops ready a cycle late, so the first cycle here ignores ready.
          if (guard) begin
            guard <= 1'b0;
          end else if (drv_ready) begin
            if (led_index == LAST_IDX) begin
              state        <= LATCH;
              drv_ws_reset <= 1'b1;
            end else begin
              state     <= LOAD;
              led_index <= led_index + 1'b1;
              drv_load  <= 1'b1;
            end
          end
        end
        LATCH: begin
          state <= LATCH_WAIT;
          guard <= 1'b1;
        end
        LATCH_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (drv_ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench: a 3-pixel and a 1-pixel sequencer, each paced by a small model of the driver's ready.
module tb_ws2812_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flash_level;
  logic       refresh;
  logic       drv_ready;
  logic       drv_load;
  logic       drv_ws_reset;
  logic [7:0] drv_r, drv_g, drv_b;
  logic       busy;
  logic       frame_done;
  logic [7:0] led_index;

  logic       drv_ready1;
  logic       drv_load1;
  logic       drv_ws_reset1;
  logic [7:0] drv_r1, drv_g1, drv_b1;
  logic       busy1;
  logic       frame_done1;
  logic [7:0] led_index1;

  int n_cmp = 0;
  int n_err = 0;
  int load_cnt = 0, latch_cnt = 0, done_cnt = 0;
  int load_cnt1 = 0, latch_cnt1 = 0, done_cnt1 = 0;
  logic [23:0] rgb1_last = 24'h0;
  logic [31:0] exp_q[$];

  int drv_cnt, drv_cnt1;

  always #10 clk = ~clk;

  ws2812_frame_sequencer #(.NUM_LEDS(3), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flash_level(flash_level),
    .refresh(refresh), .drv_ready(drv_ready), .drv_load(drv_load),
    .drv_ws_reset(drv_ws_reset), .drv_r(drv_r), .drv_g(drv_g), .drv_b(drv_b),
    .busy(busy), .frame_done(frame_done), .led_index(led_index)
  );

  ws2812_frame_sequencer #(.NUM_LEDS(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .flash_level(flash_level),
    .refresh(refresh), .drv_ready(drv_ready1), .drv_load(drv_load1),
    .drv_ws_reset(drv_ws_reset1), .drv_r(drv_r1), .drv_g(drv_g1), .drv_b(drv_b1),
    .busy(busy1), .frame_done(frame_done1), .led_index(led_index1)
  );

  // Driver model: ready falls the cycle after a load/latch, pixel busy 5 cycles, latch busy 8.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_ready <= 1'b1;
      drv_cnt   <= 0;
    end else if (drv_load || drv_ws_reset) begin
      drv_ready <= 1'b0;
      drv_cnt   <= drv_load ? 5 : 8;
    end else if (!drv_ready) begin
      if (drv_cnt == 0) drv_ready <= 1'b1;
      else drv_cnt <= drv_cnt - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_ready1 <= 1'b1;
      drv_cnt1   <= 0;
    end else if (drv_load1 || drv_ws_reset1) begin
      drv_ready1 <= 1'b0;
      drv_cnt1   <= drv_load1 ? 5 : 8;
    end else if (!drv_ready1) begin
      if (drv_cnt1 == 0) drv_ready1 <= 1'b1;
      else drv_cnt1 <= drv_cnt1 - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (drv_load || drv_ws_reset) begin
        check("load_latch_overlap", {31'b0, drv_load && drv_ws_reset}, 32'd0);
        check("pulse_with_ready", {31'b0, drv_ready}, 32'd1);
        check("busy_in_frame", {31'b0, busy}, 32'd1);
      end
      if (drv_load) begin
        load_cnt++;
        if (exp_q.size() == 0) check("unexpected_load", 32'd1, 32'd0);
        else check("pixel_idx_rgb", {led_index, drv_r, drv_g, drv_b}, exp_q.pop_front());
      end
      if (drv_ws_reset) latch_cnt++;
      if (frame_done) done_cnt++;
      if (drv_load1 || drv_ws_reset1) begin
        check("n1_load_latch_overlap", {31'b0, drv_load1 && drv_ws_reset1}, 32'd0);
        check("n1_pulse_with_ready", {31'b0, drv_ready1}, 32'd1);
      end
      if (drv_load1) begin
        load_cnt1++;
        rgb1_last = {drv_r1, drv_g1, drv_b1};
      end
      if (drv_ws_reset1) latch_cnt1++;
      if (frame_done1) done_cnt1++;
    end
  end

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    #1;
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic push_frame(input logic [23:0] rgb);
    for (int i = 0; i < 3; i++) exp_q.push_back({i[7:0], rgb});
  endtask

  initial begin
    int base_load, base_latch, base_done;
    bit seen;
    rst = 1'b1;
    enable = 1'b1;
    flash_level = 1'b1;
    refresh = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_load", {31'b0, drv_load}, 32'd0);
    check("rst_ws_reset", {31'b0, drv_ws_reset}, 32'd0);
    check("rst_busy_done", {30'b0, busy, frame_done}, 32'd0);
    check("rst_idx_rgb", {led_index, drv_r, drv_g, drv_b}, 32'd0);

    // Frame 1: level high after reset requests an on frame
    push_frame(24'h3F3F3F);
    rst = 1'b0;
    wait_done("f1_done", 500);
    check("f1_loads", load_cnt, 32'd3);
    check("f1_latches", latch_cnt, 32'd1);
    check("f1_dones", done_cnt, 32'd1);
    check("f1_queue_empty", exp_q.size(), 32'd0);
    check("n1_loads", load_cnt1, 32'd1);
    check("n1_latches", latch_cnt1, 32'd1);
    check("n1_dones", done_cnt1, 32'd1);
    check("n1_rgb", {8'h0, rgb1_last}, 32'h003F3F3F);

    // Frame 2: falling level gives an off frame
    base_load = load_cnt; base_latch = latch_cnt; base_done = done_cnt;
    push_frame(24'h000000);
    flash_level = 1'b0;
    wait_done("f2_done", 500);
    check("f2_loads", load_cnt - base_load, 32'd3);
    check("f2_latches", latch_cnt - base_latch, 32'd1);
    check("f2_dones", done_cnt - base_done, 32'd1);
    @(negedge clk);
    check("f2_busy_cleared", {31'b0, busy}, 32'd0);

    // Frame 3 by refresh; toggles and a refresh during it collapse into one more frame
    base_load = load_cnt; base_latch = latch_cnt; base_done = done_cnt;
    push_frame(24'h000000);
    push_frame(24'h000000);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (4) @(negedge clk);
    check("f3_busy", {31'b0, busy}, 32'd1);
    flash_level = 1'b1;
    @(negedge clk);
    flash_level = 1'b0;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done("f3_done", 500);
    wait_done("f4_done", 500);
    repeat (200) @(negedge clk);
    #1;
    check("f34_loads", load_cnt - base_load, 32'd6);
    check("f34_latches", latch_cnt - base_latch, 32'd2);
    check("f34_dones", done_cnt - base_done, 32'd2);
    check("f34_queue_empty", exp_q.size(), 32'd0);

    // enable low holds a pending refresh
    base_load = load_cnt;
    enable = 1'b0;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (1000) @(negedge clk);
    #1;
    check("en_low_no_load", load_cnt - base_load, 32'd0);
    check("en_low_idle", {31'b0, busy}, 32'd0);
    push_frame(24'h000000);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (drv_load) seen = 1'b1;
    end
    check("en_start_latency", {31'b0, seen}, 32'd1);
    wait_done("f5_done", 500);
    check("f5_queue_empty", exp_q.size(), 32'd0);

    // Reset during the wait after pixel 1
    exp_q.push_back({8'd0, 24'h3F3F3F});
    exp_q.push_back({8'd1, 24'h3F3F3F});
    flash_level = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (drv_load && led_index == 8'd1) seen = 1'b1;
    end
    check("mid_reach_pixel1", {31'b0, seen}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pulses", {30'b0, drv_load, drv_ws_reset}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_idx", {24'b0, led_index}, 32'd0);
    check("mid_queue_empty", exp_q.size(), 32'd0);
    base_load = load_cnt; base_latch = latch_cnt;
    push_frame(24'h3F3F3F);
    @(negedge clk);
    rst = 1'b0;
    wait_done("f6_done", 500);
    check("f6_loads", load_cnt - base_load, 32'd3);
    check("f6_latches", latch_cnt - base_latch, 32'd1);
    check("f6_queue_empty", exp_q.size(), 32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
